multi_pulse_stretcher: RTL
==========================

MULTI_PULSE_STRETCHER -- requirements
Module: multi_pulse_stretcher

Interface
REQ-001 Parameter NCH, default 4: number of independent channels, legal range 1..32.
REQ-002 Parameter CW, default 16: width of the pulse-width and delay counters, legal range 4..32.
REQ-003 Port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port pulse_in, input, NCH bits: per-channel trigger inputs, already synchronous to clk.
REQ-006 Port cfg_width, input, CW bits: output pulse length in clk cycles, shared by all channels.
REQ-007 Port cfg_delay, input, CW bits: cycles from trigger detection to output assertion, shared.
REQ-008 Port cfg_retrig, input, 1 bit: 1 = retrigger mode (extend), 0 = ignore mode.
REQ-009 Port cfg_en, input, NCH bits: per-channel enable.
REQ-010 Port clear_miss, input, 1 bit: clears all miss flags.
REQ-011 Port pulse_out, output, NCH bits: stretched pulses.
REQ-012 Port busy, output, NCH bits: channel is in DELAY or ACTIVE.
REQ-013 Port miss, output, NCH bits: sticky flag; a trigger was dropped.

Function
REQ-014 Each channel shall contain an edge detector, a CW-bit down-counter, latched copies of cfg_width and cfg_delay, and an FSM with states IDLE, DELAY and ACTIVE.
REQ-015 A trigger on channel i in cycle t shall be pulse_in[i]=1 in t, pulse_in[i]=0 in t-1 (registered sample), and cfg_en[i]=1 in t.
REQ-016 On a trigger in IDLE with cfg_width=0, the trigger shall be discarded with no state change and no miss flag.
REQ-017 On a trigger in IDLE with cfg_width>0, the channel shall latch cfg_width and cfg_delay and change state as follows.
- Latched delay 0: go to ACTIVE; pulse_out[i]=1 from cycle t+1.
- Latched delay D>0: go to DELAY; pulse_out[i]=1 from cycle t+1+D.
REQ-018 In ACTIVE, pulse_out[i] shall stay high for exactly the latched width W cycles, then the channel shall return to IDLE with pulse_out[i]=0.
REQ-019 Changes to cfg_width or cfg_delay while a channel is busy shall not affect that channel's current pulse.
REQ-020 busy[i] shall be 1 exactly while the FSM is in DELAY or ACTIVE; pulse_out[i] shall be 1 exactly while in ACTIVE.
REQ-021 A trigger during DELAY shall be dropped and shall set miss[i], in both modes.
REQ-022 A trigger during ACTIVE shall be handled by mode.
- cfg_retrig=1: reload the counter with the current cfg_width, so pulse_out stays high through cycle t+W_new, with no gap.
- cfg_retrig=0: drop the trigger and set miss[i].
REQ-023 A trigger arriving in the same cycle that ACTIVE ends shall be treated as a trigger in ACTIVE, per REQ-022.
- cfg_retrig=0: miss set; the channel returns to IDLE.
- cfg_retrig=1: the pulse is extended.
REQ-024 Deasserting cfg_en[i] shall block new triggers only; a pulse already in progress shall complete.
REQ-025 clear_miss=1 shall clear all miss bits; if a new miss occurs in the same cycle, set shall win over clear.
REQ-026 Counters shall not wrap: widths and delays up to 2^CW-1 shall be exact, and the counter shall never underflow.
REQ-027 Channels shall be fully independent; simultaneous triggers on any set of channels shall all be served.

Reset
REQ-028 While rst=1, all FSMs shall go to IDLE, and pulse_out, busy, miss and all counters shall be 0.
REQ-029 During reset, the edge-detector registers shall be loaded with 1, so a pulse_in held high through reset release does not trigger.
REQ-030 Reset asserted mid-pulse shall force pulse_out low in the first clock edge with rst=1; no pulse shall resume after reset.

Verification
REQ-031 Basic, zero delay: width=5, delay=0, 1-cycle pulse_in[0] at cycle 10 -> pulse_out[0] high for cycles 11-15, busy identical, miss=0.
REQ-032 Delay: width=3, delay=4, trigger at cycle 10 -> busy high for cycles 11-17, pulse_out high for cycles 15-17.
REQ-033 Retrigger: width=4, retrig=1, triggers at cycles 10 and 12 -> pulse_out high for cycles 11-16 continuously; ignore mode (retrig=0) with the same stimulus -> high for cycles 11-14, miss[0]=1.
REQ-034 Width 0 and enable: width=0 trigger -> no output and miss=0; cfg_en[1]=0 trigger -> no output; cfg_en[1] dropped mid-pulse -> pulse completes.
REQ-035 Boundaries: CW=4, width=15 -> exactly 15 cycles; all NCH channels triggered together -> identical pulses; clear_miss coincident with a miss -> miss stays 1.
REQ-036 Reset: rst at cycle 3 of an 8-cycle pulse -> pulse_out=0 from the next edge; pulse_in held high across reset release -> no pulse.

Source files
------------

// File: rtl/multi_pulse_stretcher.sv
// Multi-channel pulse stretcher: each channel turns a rising edge on pulse_in
// into a delayed, fixed-width output pulse, with optional retrigger extension.
module multi_pulse_stretcher #(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] pulse_in,
    input  logic [CW-1:0]  cfg_width,
    input  logic [CW-1:0]  cfg_delay,
    input  logic           cfg_retrig,
    input  logic [NCH-1:0] cfg_en,
    input  logic           clear_miss,
    output logic [NCH-1:0] pulse_out,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] miss
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        ACTIVE
    } state_t;

    localparam logic [CW-1:0] ZERO = '0;
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t         state_q [NCH];
    state_t         state_d [NCH];
    logic [CW-1:0]  cnt_q   [NCH];
    logic [CW-1:0]  cnt_d   [NCH];
    logic [CW-1:0]  width_q [NCH];
    logic [CW-1:0]  width_d [NCH];

    logic [NCH-1:0] prev_q;
    logic [NCH-1:0] trig;
    logic [NCH-1:0] miss_set;
    logic           width_zero;
    logic           delay_zero;

    assign trig       = pulse_in & ~prev_q & cfg_en;
    assign width_zero = (cfg_width == ZERO);
    assign delay_zero = (cfg_delay == ZERO);

    // The counter holds remaining delay cycles in DELAY and remaining pulse
    // cycles in ACTIVE; it is always >= 1 while busy, so it can never underflow.
    always_comb begin
        miss_set = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            width_d[i] = width_q[i];
            case (state_q[i])
                IDLE: begin
                    if (trig[i] && !width_zero) begin
                        width_d[i] = cfg_width;
                        if (delay_zero) begin
                            state_d[i] = ACTIVE;
                            cnt_d[i]   = cfg_width;
                        end else begin
                            state_d[i] = DELAY;
                            cnt_d[i]   = cfg_delay;
                        end
                    end
                end
                DELAY: begin
                    miss_set[i] = trig[i];
                    if (cnt_q[i] == ONE) begin
                        state_d[i] = ACTIVE;
                        cnt_d[i]   = width_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] - ONE;
                    end
                end
                ACTIVE: begin
                    // A zero-width retrigger is discarded like one in IDLE.
                    if (trig[i] && cfg_retrig && !width_zero) begin
                        cnt_d[i] = cfg_width;
                    end else begin
                        miss_set[i] = trig[i] & ~cfg_retrig;
                        if (cnt_q[i] == ONE) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = ZERO;
                        end else begin
                            cnt_d[i] = cnt_q[i] - ONE;
                        end
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = ZERO;
                end
            endcase
        end
    end

    always_comb begin
        pulse_out = '0;
        busy      = '0;
        for (int i = 0; i < NCH; i++) begin
            pulse_out[i] = (state_q[i] == ACTIVE);
            busy[i]      = (state_q[i] != IDLE);
        end
    end

    // Edge-detector history resets to 1 so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '1;
            miss   <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= ZERO;
                width_q[i] <= ZERO;
            end
        end else begin
            prev_q <= pulse_in;
            miss   <= (miss & ~{NCH{clear_miss}}) | miss_set;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                width_q[i] <= width_d[i];
            end
        end
    end

endmodule
